// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_port_arbiter : round-robin CPU/DMA arbiter for the unified memory macro
// Rev 1.0
// ----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2    // legal 1..15, the counter is 4 bits wide
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_done,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              owner,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [3:0] C_CNT_LOAD = 4'(MEM_LAT - 1);

  state_t            state_q, state_d;
  logic              last_q, last_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
  logic              grant_dma;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    we_d        = we_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    grant_dma   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cpu_req || dma_req) begin
          // On a tie the port that was not served last wins.
          grant_dma = dma_req && (!cpu_req || !last_q);
          owner_d   = grant_dma;
          we_d      = grant_dma ? dma_we    : cpu_we;
          addr_d    = grant_dma ? dma_addr  : cpu_addr;
          wdata_d   = grant_dma ? dma_wdata : cpu_wdata;
          cnt_d     = C_CNT_LOAD;
          state_d   = S_ACCESS;
        end
      end
      S_ACCESS: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd0) begin
          cnt_d   = 4'd0;
          state_d = S_DONE;
          if (!we_q) begin
            if (owner_q) dma_rdata_d = mem_rdata;
            else         cpu_rdata_d = mem_rdata;
          end
        end
      end
      S_DONE: begin
        last_d  = owner_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      last_q      <= 1'b1;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      cnt_q       <= 4'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  // Strobes decode straight from registered state so an async reset kills them at once.
  assign mem_read  = (state_q == S_ACCESS) && !we_q;
  assign mem_write = (state_q == S_ACCESS) && we_q && (cnt_q == C_CNT_LOAD);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_done  = (state_q == S_DONE) && !owner_q;
  assign dma_done  = (state_q == S_DONE) && owner_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;
  assign owner     = owner_q;
  assign busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mem_port_arbiter : scoreboard bench for mem_port_arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_mem_port_arbiter;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int MEM_LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic        cpu_done;
  logic [31:0] cpu_rdata;
  logic        dma_req = 1'b0, dma_we = 1'b0;
  logic [31:0] dma_addr = '0, dma_wdata = '0;
  logic        dma_done;
  logic [31:0] dma_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        owner, busy;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_done(dma_done), .dma_rdata(dma_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] f_init(input int i);
    return (i == 16) ? 32'hDEADBEEF : ((32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000);
  endfunction

  // Memory macro: data is only valid on the last cycle of the read latency window.
  logic [31:0] mem [256];
  bit          mem_init = 1'b0;
  int          rd_cnt = 0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= f_init(i);
      mem_init <= 1'b1;
    end else if (mem_write) begin
      mem[mem_addr[7:0]] <= mem_wdata;
    end
    rd_cnt <= mem_read ? rd_cnt + 1 : 0;
  end
  assign mem_rdata = (mem_read && rd_cnt == MEM_LAT - 1) ? mem[mem_addr[7:0]] : 32'hBADBAD00;

  // Reference model: shadow memory plus per-port FIFOs of expected completions.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  logic [31:0] ref_mem [256];
  exp_t        cpu_q[$];
  exp_t        dma_q[$];
  bit          grant_log[$];
  int          grant_t[$];

  // Monitor state
  bit          last_srv = 1'b1;
  logic [31:0] cpu_last = '0, dma_last = '0;
  int          acc_cyc = 0, rd_cyc = 0, wr_cyc = 0, cyc = 0;
  logic [31:0] wr_a = '0, wr_d = '0;
  bit          prev_busy = 1'b0;
  logic [1:0]  prev_req = 2'b00;
  bit          exp_own;
  exp_t        me;
  bit          have;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      last_srv  = 1'b1;
      cpu_last  = '0;
      dma_last  = '0;
      acc_cyc   = 0;
      rd_cyc    = 0;
      wr_cyc    = 0;
      prev_busy = 1'b0;
      prev_req  = 2'b00;
      cpu_q.delete();
      dma_q.delete();
    end else begin
      if (busy && !prev_busy) begin
        exp_own = (prev_req == 2'b11) ? ~last_srv : prev_req[1];
        chk(prev_req != 2'b00 && owner == exp_own, "grant_owner", {31'd0, owner}, {31'd0, exp_own});
        grant_log.push_back(owner);
        grant_t.push_back(cyc);
        acc_cyc = 0;
        rd_cyc  = 0;
        wr_cyc  = 0;
      end
      chk(!(mem_read && mem_write), "strobe_exclusive", {30'd0, mem_read, mem_write}, 32'd0);
      chk(!(cpu_done && dma_done), "done_exclusive", {30'd0, cpu_done, dma_done}, 32'd0);
      if (busy && !cpu_done && !dma_done) begin
        acc_cyc++;
        if (mem_read)  rd_cyc++;
        if (mem_write) begin
          wr_cyc++;
          wr_a = mem_addr;
          wr_d = mem_wdata;
        end
        have = owner ? (dma_q.size() != 0) : (cpu_q.size() != 0);
        chk(have, "spurious_access", {31'd0, owner}, 32'd0);
        if (have) begin
          me = owner ? dma_q[0] : cpu_q[0];
          chk(mem_addr == me.addr, "mem_addr_stable", mem_addr, me.addr);
        end
      end
      if (cpu_done || dma_done) begin
        have = dma_done ? (dma_q.size() != 0) : (cpu_q.size() != 0);
        chk(have, "done_without_request", {30'd0, dma_done, cpu_done}, 32'd0);
        chk(owner == dma_done, "done_owner", {31'd0, owner}, {31'd0, dma_done});
        chk(acc_cyc == MEM_LAT, "access_length", 32'(acc_cyc), 32'(MEM_LAT));
        if (have) begin
          me = dma_done ? dma_q.pop_front() : cpu_q.pop_front();
          if (me.we) begin
            chk(wr_cyc == 1 && rd_cyc == 0, "write_strobes", {wr_cyc[15:0], rd_cyc[15:0]}, 32'h0001_0000);
            chk(wr_a == me.addr, "write_addr", wr_a, me.addr);
            chk(wr_d == me.data, "write_data", wr_d, me.data);
          end else begin
            chk(rd_cyc == MEM_LAT && wr_cyc == 0, "read_strobes", {wr_cyc[15:0], rd_cyc[15:0]}, 32'(MEM_LAT));
            if (dma_done) dma_last = me.data;
            else          cpu_last = me.data;
          end
        end
        chk(cpu_rdata == cpu_last, "cpu_rdata", cpu_rdata, cpu_last);
        chk(dma_rdata == dma_last, "dma_rdata", dma_rdata, dma_last);
        last_srv = owner;
      end
      prev_busy = busy;
      prev_req  = {dma_req, cpu_req};
    end
  end

  // mode 0: plain, 1: drop req after grant, 2: change addr/we/wdata after grant
  task automatic do_txn(input bit p, input bit we, input logic [31:0] addr, input logic [31:0] wd,
                        input int mode, output int lat);
    exp_t e;
    bit   got, seen;
    int   n;
    e.we   = we;
    e.addr = addr;
    e.data = we ? wd : ref_mem[addr[7:0]];
    if (we) ref_mem[addr[7:0]] = wd;
    if (!p) begin
      cpu_q.push_back(e);
      cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_req = 1'b1;
    end else begin
      dma_q.push_back(e);
      dma_we = we; dma_addr = addr; dma_wdata = wd; dma_req = 1'b1;
    end
    n = 0; got = 1'b0; seen = 1'b0;
    while (!got && n < 50) begin
      @(posedge clk); #1;
      n++;
      if (p ? dma_done : cpu_done) got = 1'b1;
      else if (busy && owner == p && !seen) begin
        seen = 1'b1;
        if (mode == 1) begin
          if (!p) cpu_req = 1'b0; else dma_req = 1'b0;
        end else if (mode == 2) begin
          if (!p) begin cpu_addr ^= 32'h30; cpu_we = ~cpu_we; cpu_wdata = ~cpu_wdata; end
          else    begin dma_addr ^= 32'h30; dma_we = ~dma_we; dma_wdata = ~dma_wdata; end
        end
      end
    end
    chk(got, p ? "dma_done_timeout" : "cpu_done_timeout", 32'(n), 32'd50);
    if (!p) cpu_req = 1'b0; else dma_req = 1'b0;
    lat = n;
  endtask

  task automatic gap();
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n;
    reset = 1'b1;
    for (int i = 0; i < 256; i++) ref_mem[i] = f_init(i);
    repeat (3) @(posedge clk);
    #1;
    chk(owner == 1'b0 && busy == 1'b0, "reset_owner_busy", {30'd0, owner, busy}, 32'd0);
    chk(!mem_read && !mem_write && !cpu_done && !dma_done, "reset_strobes",
        {28'd0, mem_read, mem_write, cpu_done, dma_done}, 32'd0);
    chk(mem_addr == 0 && mem_wdata == 0, "reset_mem_bus", mem_addr | mem_wdata, 32'd0);
    chk(cpu_rdata == 0 && dma_rdata == 0, "reset_rdata", cpu_rdata | dma_rdata, 32'd0);
    reset = 1'b0;

    // Both ports hold requests straight out of reset: grants alternate starting with CPU.
    grant_log.delete();
    grant_t.delete();
    fork
      begin int l; for (int i = 0; i < 2; i++) do_txn(1'b0, 1'b0, 32'(8 * i + 4), '0, 0, l); end
      begin int l; for (int i = 0; i < 2; i++) do_txn(1'b1, 1'b0, 32'(8 * i + 'h84), '0, 0, l); end
    join
    chk(grant_log.size() == 4, "t2_grant_count", 32'(grant_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      chk(grant_log[i] == 1'(i % 2), "t2_grant_order", {31'd0, grant_log[i]}, 32'(i % 2));
    if (grant_t.size() >= 2)
      chk(grant_t[1] - grant_t[0] == MEM_LAT + 2, "t2_grant_spacing", 32'(grant_t[1] - grant_t[0]), 32'(MEM_LAT + 2));
    gap();

    do_txn(1'b0, 1'b0, 32'h10, '0, 0, lat);
    chk(lat == MEM_LAT + 1, "t1_latency", 32'(lat), 32'(MEM_LAT + 1));
    chk(cpu_rdata == 32'hDEADBEEF, "t1_rdata", cpu_rdata, 32'hDEADBEEF);
    chk(dma_done == 1'b0, "t1_dma_done", {31'd0, dma_done}, 32'd0);
    gap();

    do_txn(1'b1, 1'b1, 32'h40, 32'h5, 0, lat);
    chk(lat == MEM_LAT + 1, "t3_latency", 32'(lat), 32'(MEM_LAT + 1));
    gap();

    do_txn(1'b0, 1'b0, 32'h10, '0, 2, lat);
    chk(cpu_rdata == 32'hDEADBEEF, "t4_rdata", cpu_rdata, 32'hDEADBEEF);
    gap();

    // Reset during the first ACCESS cycle of a DMA read; CPU was served last.
    dma_q.push_back('{we: 1'b0, addr: 32'h90, data: ref_mem[8'h90]});
    dma_we = 1'b0; dma_addr = 32'h90; dma_req = 1'b1;
    n = 0;
    while (!busy && n < 10) begin @(posedge clk); #1; n++; end
    chk(busy && owner == 1'b1, "t5_dma_grant", {30'd0, busy, owner}, 32'd3);
    reset = 1'b1;
    #1;
    chk(!mem_read && !busy && !dma_done, "t5_async_abort", {29'd0, mem_read, busy, dma_done}, 32'd0);
    @(posedge clk); #1;
    chk(!dma_done && !busy, "t5_no_done", {30'd0, dma_done, busy}, 32'd0);
    cpu_q.push_back('{we: 1'b0, addr: 32'h20, data: ref_mem[8'h20]});
    cpu_we = 1'b0; cpu_addr = 32'h20; cpu_req = 1'b1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk(busy && owner == 1'b0, "t5_cpu_first", {30'd0, busy, owner}, 32'd2);
    cpu_req = 1'b0;
    dma_req = 1'b0;
    n = 0;
    while (busy && n < 20) begin @(posedge clk); #1; n++; end
    chk(!busy, "t5_return_idle", {31'd0, busy}, 32'd0);

    do_txn(1'b0, 1'b0, 32'h18, '0, 1, lat);
    chk(lat == MEM_LAT + 1, "t6_cpu_latency", 32'(lat), 32'(MEM_LAT + 1));
    do_txn(1'b1, 1'b0, 32'hA0, '0, 0, lat);
    chk(lat == MEM_LAT + 2, "t6_dma_next_idle", 32'(lat), 32'(MEM_LAT + 2));
    gap();

    // Random concurrent traffic; CPU uses 0x00-0x7F, DMA 0x80-0xFF.
    fork
      begin
        int l;
        int m;
        for (int i = 0; i < 40; i++) begin
          m = ($urandom_range(0, 9) < 7) ? 0 : int'($urandom_range(1, 2));
          do_txn(1'b0, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 127)), $urandom, m, l);
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
        end
      end
      begin
        int l;
        int m;
        for (int i = 0; i < 40; i++) begin
          m = ($urandom_range(0, 9) < 7) ? 0 : int'($urandom_range(1, 2));
          do_txn(1'b1, 1'($urandom_range(0, 1)), 32'($urandom_range(128, 255)), $urandom, m, l);
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
        end
      end
    join

    repeat (5) @(posedge clk);
    #1;
    chk(cpu_q.size() == 0 && dma_q.size() == 0, "scoreboard_drained",
        32'(cpu_q.size() + dma_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single unified instruction/data memory between two requesters: the multi-cycle CPU controller (port 0, cpu_*) and a DMA/program-loader engine (port 1, dma_*). It runs a fixed-latency access sequence per request and uses round-robin fairness when both ports request together. It sits between the CPU memory mux output (IoD-selected address) and the memory macro. Until an access completes, the CPU controller holds its state, gated by cpu_done.

Parameters:
ADDR_W, 32, address width for both ports and the memory.
DATA_W, 32, data width.
MEM_LAT, 2, memory read latency in cycles, from the first mem_read cycle to valid mem_rdata. Legal range is 1..15.

Ports:
clk  in  1  clock.
reset  in  1  reset, asynchronous, active-high.
cpu_req  in  1  CPU access request; held until cpu_done.
cpu_we  in  1  1 = write, 0 = read.
cpu_addr  in  ADDR_W  CPU address.
cpu_wdata  in  DATA_W  CPU write data.
cpu_done  out  1  one-cycle completion pulse.
cpu_rdata  out  DATA_W  read data; valid while cpu_done=1 and held until the next CPU completion.
dma_req, dma_we, dma_addr, dma_wdata, dma_done, dma_rdata: same widths and semantics, for port 1.
mem_read  out  1  memory read strobe.
mem_write  out  1  memory write strobe.
mem_addr  out  ADDR_W  memory address.
mem_wdata  out  DATA_W  memory write data.
mem_rdata  in  DATA_W  memory read data.
owner  out  1  port owning the current or last access (0 = CPU, 1 = DMA).
busy  out  1  1 in ACCESS and DONE states.

Behaviour:
- Reset (async):
  - State goes to IDLE.
  - The last-served pointer goes to 1, so the CPU wins the first tie.
  - owner=0, busy=0, all strobes and done pulses 0.
  - mem_addr, mem_wdata, cpu_rdata and dma_rdata go to 0.
  - The latency counter goes to 0.
- FSM states: IDLE, ACCESS, DONE.
- IDLE, at the clock edge:
  - No request: stay in IDLE.
  - Exactly one request: grant that port.
  - Both requesting: grant the port that is not the last-served one.
  - On a grant, latch addr, we and wdata into mem_addr, mem_wdata and an internal we register, set owner, load counter = MEM_LAT-1, and go to ACCESS.
- ACCESS:
  - Lasts exactly MEM_LAT cycles.
  - mem_addr and mem_wdata stay stable.
  - Reads: mem_read=1 on every ACCESS cycle.
  - Writes: mem_write=1 on the first ACCESS cycle only, and mem_read stays 0.
  - The counter decrements each cycle.
  - At the edge ending the cycle where counter==0: for a read, capture mem_rdata into the owner's rdata register. Then go to DONE.
- DONE:
  - Lasts one cycle.
  - The owner's done output is 1.
  - The last-served pointer updates to owner at the edge ending DONE.
  - Next state is IDLE. Arbitration happens only in IDLE, so there is one idle cycle minimum between accesses.
- Latency: with a request sampled at edge N (in IDLE), ACCESS occupies cycles N+1..N+MEM_LAT and done is high in cycle N+MEM_LAT+1. With MEM_LAT=2 this is 3 cycles to done, and 4 cycles per transaction including IDLE.
- Requester inputs are sampled only at the grant. Changes to addr, we or wdata during ACCESS are ignored.
- If req drops mid-access, the access still completes and done still pulses; the requester ignores it. No abort.
- The non-owner's done stays 0. The non-owner's rdata is never modified.
- Strobes are mutually exclusive. mem_read and mem_write are never both 1.
- Reset mid-ACCESS: strobes drop immediately (async) and no done pulse is issued. The interrupted write may or may not have committed; this is not guaranteed.
- Continuous requests from both ports: the grants strictly alternate, so neither port waits more than one transaction.

Test Plan:
1. MEM_LAT=2, CPU read of addr 0x10, memory returns 0xDEADBEEF → mem_read high for 2 cycles; cpu_done pulses in cycle 3 after the sampling edge; cpu_rdata=0xDEADBEEF; dma_done=0.
2. CPU and DMA both assert req right after reset → CPU granted first (owner=0), then DMA (owner=1) 4 cycles later. Held for 4 transactions, grants go 0,1,0,1.
3. DMA write of 0x00000005 to addr 0x40 → mem_write high for exactly 1 cycle with mem_addr=0x40 and mem_wdata=5; mem_read=0 throughout; dma_done pulses 2 cycles after the write strobe.
4. CPU changes cpu_addr from 0x10 to 0x20 during ACCESS → mem_addr stays 0x10 for the whole access.
5. Reset asserted in the first ACCESS cycle of a DMA read → mem_read=0 immediately, no dma_done, state IDLE. After release, a pending CPU request is granted first (pointer reset).
6. CPU drops cpu_req after the grant → cpu_done still pulses and cpu_rdata updates. A subsequent DMA-only request is granted on the next IDLE cycle.
